// File: rtl/melody_player.sv
`default_nettype none
// ============================================================================
//  Module      : melody_player
//  Description : Pattern-driven buzzer sequencer. Plays one of four built-in
//                8-step melodies as a square wave on 'beep'. Each step is a
//                tone (or rest) held for 1..4 beats. Patterns may repeat
//                seamlessly or end with a one-cycle 'done' pulse.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   clock, all state on the rising edge
//    rstn      in   asynchronous active-low reset
//    start     in   single-cycle request to begin a pattern (IDLE only)
//    stop      in   abort the current pattern; wins over start
//    mode[1:0] in   pattern select, captured at start
//    loop      in   repeat the pattern, captured at start
//    beep      out  square-wave buzzer drive
//    loud      out  amplifier enable (high while playing)
//    busy      out  high while a pattern plays
//    done      out  one-cycle pulse when a non-looping pattern completes
//    step_idx  out  index of the step currently playing
// ============================================================================
module melody_player #(
  parameter int unsigned HALF_W     = 16,
  parameter int unsigned DUR_W      = 24,
  parameter int unsigned BEAT_TICKS = 12500000,
  parameter int unsigned NOTE_1     = 63776,
  parameter int unsigned NOTE_2     = 56818,
  parameter int unsigned NOTE_3     = 50618,
  parameter int unsigned NOTE_4     = 47778,
  parameter int unsigned NOTE_5     = 42566,
  parameter int unsigned NOTE_6     = 37936,
  parameter int unsigned NOTE_7     = 33784
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic       loop,
  output logic       beep,
  output logic       loud,
  output logic       busy,
  output logic       done,
  output logic [2:0] step_idx
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Comparisons are carried out at the wider of the counter width and the
  // 32-bit parameter width so that neither side is ever truncated.
  localparam int unsigned TONE_CW = (HALF_W > 32) ? HALF_W : 32;
  localparam int unsigned BEAT_CW = (DUR_W  > 32) ? DUR_W  : 32;

  localparam logic [BEAT_CW-1:0] C_BEAT_LAST = BEAT_CW'(BEAT_TICKS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  // --------------------------------------------------------------------------
  // Pattern ROM: returns {code[2:0], len[1:0]} for a given mode and step.
  // code 0 is a rest, codes 1..7 select NOTE_1..NOTE_7 (C D E F G A B).
  // --------------------------------------------------------------------------
  function automatic logic [4:0] f_step(input logic [1:0] m, input logic [2:0] i);
    logic [2:0] code;
    logic [1:0] len;
    code = 3'd0;
    len  = 2'd0;
    case (m)
      2'd0: code = 3'd6;                       // continuous A
      2'd1: code = i[0] ? 3'd0 : 3'd6;         // A / rest alternating
      2'd2: begin                              // C E G rest, twice
        case (i[1:0])
          2'd0:    code = 3'd1;
          2'd1:    code = 3'd3;
          2'd2:    code = 3'd5;
          default: code = 3'd0;
        endcase
      end
      default: begin                           // descending scale + long rest
        if (i == 3'd7) begin
          code = 3'd0;
          len  = 2'd3;
        end else begin
          code = 3'd7 - i;
        end
      end
    endcase
    return {code, len};
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  logic [1:0]        r_mode;
  logic              r_loop;
  logic [HALF_W-1:0] r_tone_cnt;
  logic [DUR_W-1:0]  r_beat_cnt;   // cycles within the current beat
  logic [1:0]        r_beat_num;   // beats elapsed within the current step
  logic [2:0]        r_step_idx;
  logic              r_beep;
  logic              r_done;

  // --------------------------------------------------------------------------
  // Step decode and counter compares
  // --------------------------------------------------------------------------
  logic [4:0]         w_step;
  logic [2:0]         w_code;
  logic [1:0]         w_len;
  logic [TONE_CW-1:0] w_div;
  logic               w_tone_hit;
  logic               w_beat_last;
  logic               w_step_end;
  logic               w_finish;
  logic               w_launch;

  assign w_step = f_step(r_mode, r_step_idx);
  assign w_code = w_step[4:2];
  assign w_len  = w_step[1:0];

  always_comb begin
    w_div = '0;
    case (w_code)
      3'd1:    w_div = TONE_CW'(NOTE_1);
      3'd2:    w_div = TONE_CW'(NOTE_2);
      3'd3:    w_div = TONE_CW'(NOTE_3);
      3'd4:    w_div = TONE_CW'(NOTE_4);
      3'd5:    w_div = TONE_CW'(NOTE_5);
      3'd6:    w_div = TONE_CW'(NOTE_6);
      3'd7:    w_div = TONE_CW'(NOTE_7);
      default: w_div = '0;
    endcase
  end

  assign w_tone_hit  = (TONE_CW'(r_tone_cnt) == w_div);
  assign w_beat_last = (BEAT_CW'(r_beat_cnt) == C_BEAT_LAST);

  // A step of len L spans L+1 full beats. Splitting the count into a
  // per-beat counter and a beat index keeps the step length exact even
  // when (len+1)*BEAT_TICKS would not fit in DUR_W bits.
  assign w_step_end = (r_state == S_PLAY) && w_beat_last && (r_beat_num == w_len);
  assign w_finish   = w_step_end && (r_step_idx == 3'd7) && !r_loop;
  assign w_launch   = (r_state == S_IDLE) && start && !stop;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic (stop always wins)
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_next = S_PLAY;
        end
      end
      S_PLAY: begin
        if (stop || w_finish) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    loud = 1'b0;
    if (r_state == S_PLAY) begin
      busy = 1'b1;
      loud = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: pattern latch, tone/beat counters, step index, beep, done
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode     <= 2'd0;
      r_loop     <= 1'b0;
      r_tone_cnt <= '0;
      r_beat_cnt <= '0;
      r_beat_num <= 2'd0;
      r_step_idx <= 3'd0;
      r_beep     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_beep <= 1'b0;
        if (w_launch) begin
          r_mode     <= mode;
          r_loop     <= loop;
          r_tone_cnt <= '0;
          r_beat_cnt <= '0;
          r_beat_num <= 2'd0;
          r_step_idx <= 3'd0;
        end
      end else if (stop) begin
        // Abort: silent, back to step 0, no completion pulse.
        r_tone_cnt <= '0;
        r_beat_cnt <= '0;
        r_beat_num <= 2'd0;
        r_step_idx <= 3'd0;
        r_beep     <= 1'b0;
      end else if (w_step_end) begin
        // Every new step begins with beep low and a fresh tone phase.
        r_tone_cnt <= '0;
        r_beat_cnt <= '0;
        r_beat_num <= 2'd0;
        r_beep     <= 1'b0;
        if (w_finish) begin
          r_done     <= 1'b1;
          r_step_idx <= 3'd0;
        end else begin
          r_step_idx <= r_step_idx + 3'd1;   // 7 -> 0 wraps when looping
        end
      end else begin
        if (w_beat_last) begin
          r_beat_cnt <= '0;
          r_beat_num <= r_beat_num + 2'd1;
        end else begin
          r_beat_cnt <= r_beat_cnt + DUR_W'(1);
        end

        if (w_code == 3'd0) begin
          r_tone_cnt <= '0;
          r_beep     <= 1'b0;
        end else if (w_tone_hit) begin
          // Half-period is divisor+1 cycles.
          r_tone_cnt <= '0;
          r_beep     <= ~r_beep;
        end else begin
          r_tone_cnt <= r_tone_cnt + HALF_W'(1);
        end
      end
    end
  end

  assign beep     = r_beep;
  assign done     = r_done;
  assign step_idx = r_step_idx;

endmodule
`default_nettype wire

// File: tb/tb_melody_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_melody_player
//  Description : Directed self-checking bench for melody_player with short
//                beats (20 cycles) and tiny divisors (NOTE_n = n).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_melody_player;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [1:0] mode  = 2'd0;
  logic       loop  = 1'b0;
  logic       beep;
  logic       loud;
  logic       busy;
  logic       done;
  logic [2:0] step_idx;

  int n_cmp = 0;
  int n_bad = 0;

  melody_player #(
    .HALF_W     (16),
    .DUR_W      (24),
    .BEAT_TICKS (20),
    .NOTE_1     (1),
    .NOTE_2     (2),
    .NOTE_3     (3),
    .NOTE_4     (4),
    .NOTE_5     (5),
    .NOTE_6     (6),
    .NOTE_7     (7)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .loop     (loop),
    .beep     (beep),
    .loud     (loud),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected note code per pattern step (0 = rest, 6 = A, ...).
  function automatic int exp_code(input int m, input int s);
    int c;
    c = 0;
    case (m)
      0: c = 6;
      1: c = (s % 2 == 0) ? 6 : 0;
      2: begin
        case (s % 4)
          0:       c = 1;
          1:       c = 3;
          2:       c = 5;
          default: c = 0;
        endcase
      end
      default: c = (s < 7) ? 7 - s : 0;
    endcase
    return c;
  endfunction

  function automatic int step_len(input int m, input int s);
    return (m == 3 && s == 7) ? 80 : 20;
  endfunction

  function automatic int pat_len(input int m);
    return (m == 3) ? 220 : 160;
  endfunction

  // Checks play cycles t0..t1-1, where t=0 is the first cycle after the
  // start edge. Leaves the bench at the negedge of cycle t1.
  task automatic play_check(input int m, input bit lp, input int t0, input int t1);
    for (int t = t0; t < t1; t++) begin
      int tt;
      int s;
      int p;
      int c;
      int eb;
      tt = lp ? (t % pat_len(m)) : t;
      s  = 0;
      p  = tt;
      while (p >= step_len(m, s)) begin
        p -= step_len(m, s);
        s++;
      end
      c  = exp_code(m, s);
      eb = (c != 0 && ((p / (c + 1)) % 2) == 1) ? 1 : 0;
      chk($sformatf("m%0d t%0d busy", m, t), busy, 1);
      chk($sformatf("m%0d t%0d loud", m, t), loud, 1);
      chk($sformatf("m%0d t%0d step_idx", m, t), step_idx, s);
      chk($sformatf("m%0d t%0d beep", m, t), beep, eb);
      chk($sformatf("m%0d t%0d done", m, t), done, 0);
      @(negedge clk);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " loud"}, loud, 0);
    chk({tag, " beep"}, beep, 0);
    chk({tag, " step_idx"}, step_idx, 0);
    chk({tag, " done"}, done, exp_done);
  endtask

  initial begin
    // ---------------- reset state ----------------
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset", 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    chk_idle("post_reset", 1'b0);

    // ---------------- mode 0, single pass ----------------
    mode  = 2'd0;
    loop  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    play_check(0, 1'b0, 0, 160);
    chk_idle("m0 end", 1'b1);
    @(negedge clk);
    chk_idle("m0 after", 1'b0);

    // ---------------- mode 1, looped, then stop ----------------
    mode  = 2'd1;
    loop  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'd3;          // changes after start must not matter
    loop  = 1'b0;
    play_check(1, 1'b1, 0, 330);
    chk("m1 pre-stop beep", beep, 1);
    chk("m1 pre-stop step", step_idx, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk_idle("m1 stop", 1'b0);
    @(negedge clk);
    chk_idle("m1 stop+1", 1'b0);

    // ---------------- mode 3, single pass ----------------
    mode  = 2'd3;
    loop  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    play_check(3, 1'b0, 0, 220);
    chk_idle("m3 end", 1'b1);
    @(negedge clk);
    chk_idle("m3 after", 1'b0);

    // ---------------- start and stop together ----------------
    mode  = 2'd0;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk_idle("start+stop", 1'b0);
    @(negedge clk);
    chk_idle("start+stop+1", 1'b0);

    // ---------------- start during PLAY is ignored ----------------
    mode  = 2'd2;
    loop  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    play_check(2, 1'b0, 0, 30);
    start = 1'b1;
    mode  = 2'd0;
    loop  = 1'b1;
    play_check(2, 1'b0, 30, 31);
    start = 1'b0;
    play_check(2, 1'b0, 31, 160);
    chk_idle("m2 end", 1'b1);
    @(negedge clk);
    chk_idle("m2 after", 1'b0);

    // ---------------- reset mid-pattern ----------------
    mode  = 2'd2;
    loop  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    play_check(2, 1'b0, 0, 25);
    chk("rst pre beep", beep, 1);
    chk("rst pre step", step_idx, 1);
    rstn = 1'b0;
    #1;
    chk_idle("rst async", 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk_idle("rst release", 1'b0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    play_check(2, 1'b0, 0, 40);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk_idle("final stop", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/melody_player.md
MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 SHALL have parameter HALF_W, default 16: width of half-period divisors and the tone counter.
REQ-002 SHALL have parameter DUR_W, default 24: width of the beat counter.
REQ-003 SHALL have parameter BEAT_TICKS, default 12500000: clk cycles per beat.
REQ-004 SHALL have parameters NOTE_1..NOTE_7, defaults 63776, 56818, 50618, 47778, 42566, 37936, 33784: half-period divisors for tones C, D, E, F, G, A, B.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to begin a pattern.
REQ-008 SHALL have port stop, input, 1 bit: abort the current pattern.
REQ-009 SHALL have port mode, input, 2 bits: pattern select, sampled at start.
REQ-010 SHALL have port loop, input, 1 bit: repeat the pattern, sampled at start.
REQ-011 SHALL have port beep, output, 1 bit: square-wave buzzer drive.
REQ-012 SHALL have port loud, output, 1 bit: amplifier enable.
REQ-013 SHALL have port busy, output, 1 bit: high while a pattern plays.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a non-looping pattern completes.
REQ-015 SHALL have port step_idx, output, 3 bits: index of the current step.

Function
REQ-016 SHALL implement states IDLE and PLAY.
REQ-017 SHALL hold four internal patterns of 8 steps; each step = {code 3b, len 2b}; step lasts (len+1)*BEAT_TICKS cycles; code 0 = rest, codes 1..7 = NOTE_1..NOTE_7.
REQ-018 SHALL use mode 0: A for 8 steps, len 0 (continuous A when looped).
REQ-019 SHALL use mode 1: A, rest, A, rest, A, rest, A, rest, each len 0.
REQ-020 SHALL use mode 2: C, E, G, rest, C, E, G, rest, each len 0.
REQ-021 SHALL use mode 3: B, A, G, F, E, D, C each len 0, then a rest with len 3.
REQ-022 In IDLE, start=1 and stop=0 SHALL latch mode and loop, clear the tone and beat counters, set step_idx=0, and enter PLAY next cycle.
REQ-023 In PLAY, the tone counter SHALL increment each cycle for a tone step; when it equals the step's divisor it SHALL clear and beep SHALL toggle, giving a half-period of divisor+1 cycles.
REQ-024 beep SHALL be 0 during rest steps, in IDLE, and at the first cycle of every step (the tone counter clears on each step change).
REQ-025 The beat counter SHALL count cycles within a step; at (len+1)*BEAT_TICKS-1 it SHALL clear and step_idx SHALL advance.
REQ-026 At the end of step 7 with loop latched, step_idx SHALL wrap to 0 and play SHALL continue with no gap cycle.
REQ-027 At the end of step 7 without loop, the block SHALL enter IDLE, pulse done=1 for exactly one cycle, and force beep=0.
REQ-028 stop=1 in any state SHALL force IDLE next cycle with beep=0, step_idx=0, and no done pulse.
REQ-029 stop=1 together with start=1 SHALL leave the block in IDLE (stop wins).
REQ-030 start while in PLAY SHALL be ignored; changes to mode or loop during PLAY SHALL have no effect.
REQ-031 busy and loud SHALL both be 1 exactly while in PLAY.
REQ-032 Counter comparisons SHALL be unsigned at full parameter width, with no truncation of divisor or BEAT_TICKS.

Reset
REQ-033 rstn=0 SHALL immediately force IDLE with beep=0, loud=0, busy=0, done=0, step_idx=0, all counters 0, and latched mode/loop 0.
REQ-034 Reset asserted mid-pattern SHALL abort the pattern, and no done pulse SHALL follow.

Verification (BEAT_TICKS=20, NOTE_1..7=1..7)
REQ-035 Bench SHALL cover: mode 0, loop 0, start pulse -> busy rises next cycle; beep toggles every 7 cycles; step_idx 0..7 at 20-cycle intervals; done pulse after 160 cycles; busy and loud fall.
REQ-036 Bench SHALL cover: mode 1, loop 1 -> beep toggles only in even steps; step_idx wraps 7->0; done never asserts; stop then yields IDLE and beep=0 the next cycle.
REQ-037 Bench SHALL cover: mode 3, loop 0 -> step 7 rest lasts 80 cycles with beep=0; total play time is 220 cycles; then a single done pulse.
REQ-038 Bench SHALL cover: start and stop in the same cycle -> busy stays 0; a start during PLAY with a different mode -> pattern unchanged.
REQ-039 Bench SHALL cover: rstn low during mode 2 step 1 -> all outputs 0 immediately; after release, no done pulse, and a new start plays from step 0.
